// File: rtl/prom_pkg.sv
// Shared constants for the 256x4 PROM read path.
// State encoding and PROM geometry, common to controller and PROM models.
package prom_pkg;

  localparam int PROM_AW = 8;
  localparam int PROM_DW = 4;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = IDLE,
    ST_ACCESS = ACCESS,
    ST_DONE   = DONE
  } state_t;

  // PROM addresses wrap at the top of the 256-word array
  function automatic logic [PROM_AW-1:0] addr_inc(
    input logic [PROM_AW-1:0] a
  );
    return a + 1'b1;
  endfunction

endpackage

// File: rtl/prom_wait_timer.sv
// Access-wait counter: counts 0..WAIT, flags the sampling cycle.
// Clear has priority over count enable.
module prom_wait_timer
  import prom_pkg::*;
#(
  parameter int WAIT = 2
) (
  input  logic clk,
  input  logic rst_,
  input  logic clr_i,
  input  logic en_i,
  output logic term_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = (cnt_q == 4'(WAIT));

endmodule

// File: rtl/prom_nibble_reader.sv
// Fetches NIBBLES consecutive 4-bit PROM words into one wide word.
// Chip selects stay low for the whole fetch; valid pulses once at the end.
module prom_nibble_reader
  import prom_pkg::*;
#(
  parameter int NIBBLES = 2,
  parameter int WAIT    = 2
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic                   req,
  input  logic [PROM_AW-1:0]     start_a,
  output logic                   busy,
  output logic                   valid,
  output logic [4*NIBBLES-1:0]   data,
  output logic [PROM_AW-1:0]     rom_a,
  output logic                   rom_cs1_,
  output logic                   rom_cs2_,
  input  logic [PROM_DW-1:0]     rom_q
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  state_t               state_q, state_d;
  logic [PROM_AW-1:0]   addr_q, addr_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [4*NIBBLES-1:0] data_q, data_d;
  logic                 tmr_clr;
  logic                 tmr_en;
  logic                 tmr_term;

  prom_wait_timer #(
    .WAIT(WAIT)
  ) u_timer (
    .clk    (clk),
    .rst_   (rst_),
    .clr_i  (tmr_clr),
    .en_i   (tmr_en),
    .term_o (tmr_term)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    data_d  = data_q;
    tmr_clr = 1'b1;
    tmr_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d  = start_a;
          idx_d   = '0;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        tmr_clr = 1'b0;
        tmr_en  = 1'b1;
        if (tmr_term) begin
          data_d[PROM_DW*int'(idx_q) +: PROM_DW] = rom_q;
          tmr_clr = 1'b1;
          if (idx_q == LAST) begin
            state_d = ST_DONE;
          end else begin
            idx_d  = idx_q + 1'b1;
            addr_d = addr_inc(addr_q);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  assign busy     = (state_q == ST_ACCESS);
  assign valid    = (state_q == ST_DONE);
  assign rom_cs1_ = ~busy;
  assign rom_cs2_ = ~busy;
  assign rom_a    = addr_q;
  assign data     = data_q;

endmodule

// File: tb/tb_prom_nibble_reader.sv
// Bench for prom_nibble_reader: three parameterisations against a
// behavioural PROM image and a cycle-level fetch model.
module tb_prom_nibble_reader;

  logic       clk = 1'b0;
  logic [2:0] rst_n;
  logic [2:0] req;
  logic [7:0] sa [3];
  logic [2:0] busy, vld, cs1, cs2;
  logic [7:0] ra [3];
  logic [3:0] rq [3];
  logic [31:0] dat [3];
  logic [7:0]  d0, d1;
  logic [15:0] d2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [3:0] prom(input logic [7:0] a);
    return 4'((int'(a[3:0]) + int'(a[7:4])) % 16);
  endfunction

  function automatic int nn(input int d);
    return (d == 2) ? 4 : 2;
  endfunction

  function automatic int ww(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 0 : 1);
  endfunction

  function automatic logic [31:0] exp_data(input int d, input logic [7:0] s);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < nn(d); k++)
      r = r | (32'(prom(8'((int'(s) + k) % 256))) << (4 * k));
    return r;
  endfunction

  assign rq[0] = prom(ra[0]);
  assign rq[1] = prom(ra[1]);
  assign rq[2] = prom(ra[2]);
  assign dat[0] = 32'(d0);
  assign dat[1] = 32'(d1);
  assign dat[2] = 32'(d2);

  prom_nibble_reader #(.NIBBLES(2), .WAIT(2)) u0 (
    .clk(clk), .rst_(rst_n[0]), .req(req[0]), .start_a(sa[0]),
    .busy(busy[0]), .valid(vld[0]), .data(d0), .rom_a(ra[0]),
    .rom_cs1_(cs1[0]), .rom_cs2_(cs2[0]), .rom_q(rq[0]));

  prom_nibble_reader #(.NIBBLES(2), .WAIT(0)) u1 (
    .clk(clk), .rst_(rst_n[1]), .req(req[1]), .start_a(sa[1]),
    .busy(busy[1]), .valid(vld[1]), .data(d1), .rom_a(ra[1]),
    .rom_cs1_(cs1[1]), .rom_cs2_(cs2[1]), .rom_q(rq[1]));

  prom_nibble_reader #(.NIBBLES(4), .WAIT(1)) u2 (
    .clk(clk), .rst_(rst_n[2]), .req(req[2]), .start_a(sa[2]),
    .busy(busy[2]), .valid(vld[2]), .data(d2), .rom_a(ra[2]),
    .rom_cs1_(cs1[2]), .rom_cs2_(cs2[2]), .rom_q(rq[2]));

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // One fetch from an IDLE cycle; checks every cycle through DONE+1
  task automatic fetch(input int d, input logic [7:0] s);
    int last;
    logic [7:0] a;
    string t;
    last = nn(d) * (ww(d) + 1);
    t = $sformatf("u%0d_s%02h", d, s);
    chk({t, "_idle_busy"}, 32'(busy[d]), 0);
    chk({t, "_idle_cs"}, 32'(cs1[d]), 1);
    req[d] = 1'b1;
    sa[d]  = s;
    @(negedge clk);
    req[d] = 1'b0;
    sa[d]  = 8'($urandom);
    for (int c = 1; c <= last; c++) begin
      a = 8'((int'(s) + (c - 1) / (ww(d) + 1)) % 256);
      chk($sformatf("%s_c%0d_addr", t, c), 32'(ra[d]), 32'(a));
      chk($sformatf("%s_c%0d_cs1", t, c), 32'(cs1[d]), 0);
      chk($sformatf("%s_c%0d_cs2", t, c), 32'(cs2[d]), 0);
      chk($sformatf("%s_c%0d_busy", t, c), 32'(busy[d]), 1);
      chk($sformatf("%s_c%0d_valid", t, c), 32'(vld[d]), 0);
      @(negedge clk);
    end
    chk({t, "_done_valid"}, 32'(vld[d]), 1);
    chk({t, "_done_busy"}, 32'(busy[d]), 0);
    chk({t, "_done_cs1"}, 32'(cs1[d]), 1);
    chk({t, "_done_cs2"}, 32'(cs2[d]), 1);
    chk({t, "_done_data"}, dat[d], exp_data(d, s));
    @(negedge clk);
    chk({t, "_post_valid"}, 32'(vld[d]), 0);
    chk({t, "_post_data"}, dat[d], exp_data(d, s));
  endtask

  initial begin
    logic [7:0] s1, s2;
    int nv;
    rst_n = 3'b000;
    req   = 3'b000;
    for (int i = 0; i < 3; i++) sa[i] = 8'($urandom);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_u%0d_data", i), dat[i], 0);
      chk($sformatf("rst_u%0d_addr", i), 32'(ra[i]), 0);
      chk($sformatf("rst_u%0d_cs", i), 32'({cs1[i], cs2[i]}), 3);
      chk($sformatf("rst_u%0d_bv", i), 32'({busy[i], vld[i]}), 0);
    end
    rst_n = 3'b111;
    @(negedge clk);

    fetch(0, 8'h12);
    chk("dir_default_data", dat[0], 32'h43);
    fetch(1, 8'hFF);
    chk("dir_wrap_data", dat[1], 32'h0E);
    fetch(2, 8'h10);
    chk("dir_sweep_data", dat[2], 32'h4321);

    // back-to-back with req held high on u0
    s1 = 8'($urandom);
    s2 = 8'($urandom);
    nv = 0;
    for (int c = 0; c <= 16; c++) begin
      chk($sformatf("b2b_c%0d_valid", c), 32'(vld[0]),
          32'(c == 7 || c == 15));
      chk($sformatf("b2b_c%0d_busy", c), 32'(busy[0]),
          32'((c >= 1 && c <= 6) || (c >= 9 && c <= 14)));
      if (vld[0]) nv++;
      if (c == 7) chk("b2b_data1", dat[0], exp_data(0, s1));
      if (c == 15) chk("b2b_data2", dat[0], exp_data(0, s2));
      req[0] = (c != 16);
      sa[0]  = (c == 0) ? s1 : s2;
      @(negedge clk);
    end
    chk("b2b_valid_count", 32'(nv), 2);

    // reset in the middle of a default fetch
    req[0] = 1'b1;
    sa[0]  = 8'h12;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      req[0] = 1'b0;
      if (c == 4) rst_n[0] = 1'b0;
    end
    chk("mid_rst_cs", 32'({cs1[0], cs2[0]}), 3);
    chk("mid_rst_addr", 32'(ra[0]), 0);
    chk("mid_rst_busy", 32'(busy[0]), 0);
    chk("mid_rst_valid", 32'(vld[0]), 0);
    chk("mid_rst_data", dat[0], 0);
    rst_n[0] = 1'b1;
    @(negedge clk);
    chk("mid_rst_idle_valid", 32'(vld[0]), 0);
    fetch(0, 8'h12);
    chk("after_rst_data", dat[0], 32'h43);

    // random fetches on every configuration
    for (int i = 0; i < 4; i++)
      for (int d = 0; d < 3; d++)
        fetch(d, 8'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
